pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register with a valid/ready handshake and a one-entry skid buffer.
//  Carries a control bundle (regdsts..branch, aluctrl) and a data bundle (instruct, data, r, regdst) between stages.
//  Supports stall back-pressure, flush (bubble insertion) and reset.
//  Instantiated between IF/ID/EX/MEM/WB in place of fixed-width enable-only stage registers.
// PARAMETERS
//  CTRL_W  13   control bundle width; all-zero control = NOP/bubble
//  DATA_W  101  data bundle width (instruct 32 + data 32 + r 32 + regdst 5)
//  CNT_W   16   stall counter width (used only with PIPE_STAGE_STALL_CNT_EN)
// PORTS
//  ck         in   1       clock, all state updates on posedge
//  rst        in   1       reset, asynchronous, active-high
//  flush      in   1       synchronous flush; discards both entries, inserts bubble
//  in_valid   in   1       upstream stage presents in_ctrl/in_data
//  in_ready   out  1       stage can accept this cycle (registered)
//  in_ctrl    in   CTRL_W  incoming control bundle
//  in_data    in   DATA_W  incoming data bundle
//  out_valid  out  1       out_ctrl/out_data hold a valid entry
//  out_ready  in   1       downstream stage consumes this cycle
//  out_ctrl   out  CTRL_W  outgoing control bundle; forced 0 when out_valid=0
//  out_data   out  DATA_W  outgoing data bundle
//  stall_cnt  out  CNT_W   stall cycles seen (present only with PIPE_STAGE_STALL_CNT_EN)
// BEHAVIOUR
//  - Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Storage: main reg (drives outputs) + skid reg. State: EMPTY, FULL (main), SKID (main+skid).
//  - in_ready = 1 in EMPTY/FULL, 0 in SKID; a flop-driven output, no combinational path from out_ready.
//  - out_valid = 1 in FULL/SKID. Latency in->out: 1 cycle. Throughput: 1 transfer/cycle when out_ready=1.
//  - Transitions (no flush):
//    EMPTY: in_fire -> main<=in, FULL; else stay.
//    FULL:  in_fire & out_ready -> main<=in, stay FULL; !in_fire & out_ready -> EMPTY;
//           in_fire & !out_ready -> skid<=in, SKID; else hold.
//    SKID:  out_ready -> main<=skid, FULL; else hold (in_ready=0, in_valid ignored).
//  - Ordering: strict FIFO; the skid entry always exits after the main entry; no entry dropped or duplicated.
//  - flush (priority over every transition): next state EMPTY, out_valid=0, out_ctrl=0, in_ready=1;
//    an in_fire in the flush cycle is discarded; out_data may hold stale value (don't-care while invalid).
//  - Bubble rule: out_ctrl == 0 in any cycle with out_valid == 0, including right after reset or flush.
//  - Simultaneous flush + out_ready in SKID: both entries discarded, no output transfer counted downstream.
//  - Reset (async assert, sync-safe release): state EMPTY, out_valid=0, in_ready=1, out_ctrl=0,
//    out_data=0, skid=0, stall_cnt=0. Reset mid-transfer discards all held entries.
//  - Widths: payload passes bit-exact; no arithmetic on payload.
// CONFIGURATION
//  PIPE_STAGE_STALL_CNT_EN defined: stall_cnt port present; increments once per cycle with
//    out_valid=1 & out_ready=0; saturates at 2^CNT_W-1; cleared only by rst (flush does not clear).
//  Undefined: stall_cnt port and counter logic absent; every other behaviour is identical.
// TESTING
//  1 Reset: assert rst mid-cycle with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1 at once.
//  2 Streaming: out_ready=1, drive in_data=1..8 on consecutive cycles -> out_data 1..8 one cycle later, no gaps.
//  3 Skid: FULL with A, hold out_ready=0, send B -> in_ready=0 next cycle; release -> A then B, in_ready=1.
//  4 Flush in SKID with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0; C never appears at output.
//  5 Bubble: after drain, out_valid=0 and in_ctrl=13'h1FFF held with in_valid=0 -> out_ctrl stays 0.
//  6 PIPE_STAGE_STALL_CNT_EN, CNT_W=4: 20 stall cycles -> stall_cnt=15; flush -> 15; rst -> 0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage register with one-entry skid buffer
// Optional stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_skid #(
  parameter int CTRL_W = 13,
  parameter int DATA_W = 101
`ifdef PIPE_STAGE_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;

  logic                in_fire;
  logic                ld_main_in;
  logic                ld_main_skid;
  logic                ld_skid;

  assign in_fire = in_valid & in_ready_q;

  // State register; in_ready is registered from the next state so it never depends on out_ready combinationally
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_SKID);
    end
  end

  // Next-state and load-select decode; flush overrides every transition
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            ld_main_in = 1'b1;
            state_d    = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_ready) begin
            ld_main_in = 1'b1;
          end else if (!in_fire && out_ready) begin
            state_d = ST_EMPTY;
          end else if (in_fire) begin
            ld_skid = 1'b1;
            state_d = ST_SKID;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            ld_main_skid = 1'b1;
            state_d      = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Output decode; control is forced to zero whenever the stage holds no entry (bubble = NOP)
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = in_ready_q;
    out_ctrl  = out_valid ? main_ctrl_q : '0;
    out_data  = main_data_q;
  end

  // Main entry register: loads from the input or is refilled from the skid entry
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else if (ld_main_in) begin
      main_ctrl_q <= in_ctrl;
      main_data_q <= in_data;
    end else if (ld_main_skid) begin
      main_ctrl_q <= skid_ctrl_q;
      main_data_q <= skid_data_q;
    end
  end

  // Skid entry register: captures the input accepted while the output is stalled
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (ld_skid) begin
      skid_ctrl_q <= in_ctrl;
      skid_data_q <= in_data;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating stall counter; only reset clears it, flush leaves it alone
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
